alarm_clock_core: RTL

Single-clock, multi-alarm timekeeping core. It replaces the ripple-clocked seconds/minutes/hours chain and single alarm with a synchronous prescaler, counters with enable-based carry, a day-of-week counter, NA independent alarm slots and a ring/snooze state machine. It sits between the front-panel button conditioning and the 7-segment display drivers, which consume its binary outputs.

---
 rtl/alarm_clock_core.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_clock_core.sv
// Single-clock timekeeping core: prescaled seconds tick, h:m:s/day counters,
// NA alarm slots and a ring/snooze sequencer feeding the display and buzzer.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | quiet, waiting for an alarm match after a time update
// ST_RING   | buzzer on, auto-off timer running
// ST_SNOOZE | buzzer off, snooze timer running until re-ring
module alarm_clock_core #(
    parameter int CLK_PER_SEC = 1,
    parameter int NA          = 2,
    parameter int NDAYS       = 7,
    parameter int SNOOZE_MIN  = 9,
    parameter int RING_SEC    = 60,
    localparam int ASW = (NA > 1) ? $clog2(NA) : 1,
    localparam int DW  = (NDAYS > 1) ? $clog2(NDAYS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           timeset,
    input  logic           alarmset,
    input  logic [ASW-1:0] asel,
    input  logic           minadv,
    input  logic           hrsadv,
    input  logic [NA-1:0]  alarmon,
    input  logic           snooze,
    input  logic           stop,
    output logic           tick,
    output logic [5:0]     sec,
    output logic [5:0]     min,
    output logic [4:0]     hrs,
    output logic [DW-1:0]  day,
    output logic [5:0]     amin,
    output logic [4:0]     ahrs,
    output logic           buzz,
    output logic [ASW-1:0] buzz_src
);

    localparam int PW           = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int CNT_MAX      = (SNOOZE_TICKS > RING_SEC) ? SNOOZE_TICKS : RING_SEC;
    localparam int CW           = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0] PRE_LAST    = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_ONE     = PW'(1);
    localparam logic [DW-1:0] DAY_LAST    = DW'(NDAYS - 1);
    localparam logic [DW-1:0] DAY_ONE     = DW'(1);
    localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC);
    localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_TICKS);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    logic [PW-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_ONE;
        end
    end

    // upd_norm marks the cycle after a free-running time update; only then
    // may an alarm fire, so edits in set mode never trigger by themselves.
    logic upd_norm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec      <= '0;
            min      <= '0;
            hrs      <= '0;
            day      <= '0;
            upd_norm <= 1'b0;
        end else begin
            upd_norm <= tick && !timeset;
            if (tick) begin
                if (timeset) begin
                    if (minadv) min <= inc60(min);
                    if (hrsadv) hrs <= inc24(hrs);
                end else begin
                    sec <= inc60(sec);
                    if (sec == 6'd59) begin
                        min <= inc60(min);
                        if (min == 6'd59) begin
                            hrs <= inc24(hrs);
                            if (hrs == 5'd23)
                                day <= (day == DAY_LAST) ? '0 : day + DAY_ONE;
                        end
                    end
                end
            end
        end
    end

    logic [5:0] amin_r [NA];
    logic [4:0] ahrs_r [NA];
    logic       asel_ok;
    logic       aset_en;

    assign asel_ok = (32'(asel) < 32'(NA));
    assign aset_en = tick && alarmset && !timeset && asel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NA; i++) begin
                amin_r[i] <= '0;
                ahrs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NA; i++) begin
                if (aset_en && (asel == ASW'(i))) begin
                    if (minadv) amin_r[i] <= inc60(amin_r[i]);
                    if (hrsadv) ahrs_r[i] <= inc24(ahrs_r[i]);
                end
            end
        end
    end

    assign amin = asel_ok ? amin_r[asel] : 6'd0;
    assign ahrs = asel_ok ? ahrs_r[asel] : 5'd0;

    logic [NA-1:0]  hit;
    logic [ASW-1:0] trig_src;
    logic           trig;

    // Descending scan so the lowest matching slot is the one left in trig_src.
    always_comb begin
        hit      = '0;
        trig_src = '0;
        for (int i = 0; i < NA; i++)
            hit[i] = alarmon[i] && (amin_r[i] == min) && (ahrs_r[i] == hrs);
        for (int i = NA - 1; i >= 0; i--)
            if (hit[i]) trig_src = ASW'(i);
    end

    assign trig = upd_norm && (sec == 6'd0) && (|hit);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          src_on;

    assign src_on = alarmon[buzz_src];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            buzz_src <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state    <= ST_RING;
                        cnt      <= RING_LOAD;
                        buzz_src <= trig_src;
                    end
                end
                ST_RING: begin
                    if (stop || !src_on) begin
                        state <= ST_IDLE;
                    end else if (snooze) begin
                        state <= ST_SNOOZE;
                        cnt   <= SNOOZE_LOAD;
                    end else if (tick) begin
                        if (cnt == CNT_ONE) state <= ST_IDLE;
                        else                cnt   <= cnt - CNT_ONE;
                    end
                end
                ST_SNOOZE: begin
                    if (stop || !src_on) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (cnt == CNT_ONE) begin
                            state <= ST_RING;
                            cnt   <= RING_LOAD;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign buzz = (state == ST_RING);

endmodule
